// File: rtl/phy_tx_stripe_ser_if.sv
// -----------------------------------------------------------------------------
// phy_tx_stripe_ser_if
// Word-side handshake plus serial lane outputs of the striping TX back-end.
//   valid_in    : Data_in holds a word to transmit
//   Data_in     : DATA_W-bit word, symbol 0 in the most significant bits
//   ready_out   : word taken on an edge where valid_in & ready_out
//   Data_out    : one serial bit per lane (bit i = lane i)
//   data_active : lanes are shifting a data word rather than idle symbols
//   sync_done   : post-reset idle sync phase has completed
// master = word source / lane sink, slave = the PHY itself.
// -----------------------------------------------------------------------------
interface phy_tx_stripe_ser_if #(
  parameter int DATA_W = 32,
  parameter int LANES  = 2
) ();
  logic              valid_in;
  logic [DATA_W-1:0] Data_in;
  logic              ready_out;
  logic [LANES-1:0]  Data_out;
  logic              data_active;
  logic              sync_done;

  modport master (
    output valid_in, Data_in,
    input  ready_out, Data_out, data_active, sync_done
  );

  modport slave (
    input  valid_in, Data_in,
    output ready_out, Data_out, data_active, sync_done
  );
endinterface

// File: rtl/phy_tx_stripe_ser.sv
// -----------------------------------------------------------------------------
// phy_tx_stripe_ser
// Transmit PHY back-end: takes DATA_W-bit words over a valid/ready handshake,
// stripes SYM_W-bit symbols round-robin across LANES serial lanes and shifts
// each lane out MSB-first on the single bit clock. Symbol s goes to lane
// s % LANES, slot s / LANES; slot 0 leaves first. When no word is pending the
// lanes carry IDLE_SYM. After reset SYNC_WORDS idle word periods are sent
// before the first word may be accepted.
// Ports:
//   clk_32f : bit clock, all state on the rising edge
//   reset   : asynchronous active-low reset
//   tx      : slave side of phy_tx_stripe_ser_if (handshake, lanes, status)
// DATA_W must be a multiple of LANES*SYM_W; SYNC_WORDS must be at least 1.
// -----------------------------------------------------------------------------
module phy_tx_stripe_ser #(
  parameter int              DATA_W     = 32,
  parameter int              LANES      = 2,
  parameter int              SYM_W      = 8,
  parameter logic [SYM_W-1:0] IDLE_SYM  = 8'hBC,
  parameter int              SYNC_WORDS = 4
) (
  input logic               clk_32f,
  input logic               reset,
  phy_tx_stripe_ser_if.slave tx
);

  localparam int WB     = DATA_W / LANES;   // bits per lane per word = word period
  localparam int SPL    = WB / SYM_W;       // symbols per lane per word
  localparam int CNT_W  = (WB > 1) ? $clog2(WB) : 1;
  localparam int WCNT_W = $clog2(SYNC_WORDS + 1);
  localparam logic [WB-1:0] IDLE_PAT = {SPL{IDLE_SYM}};

  typedef enum logic {
    ST_SYNC,
    ST_ACTIVE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [CNT_W-1:0]    r_bit_cnt;
  logic [WCNT_W-1:0]   r_word_cnt;
  logic                r_hold_full;
  logic [DATA_W-1:0]   r_hold;
  logic [WB-1:0]       r_sh [LANES];
  logic                r_data_active;
  logic                r_sync_done;

  logic                w_ld;
  logic                w_sync_last;
  logic                w_ready;
  logic                w_accept;
  logic [WB-1:0]       w_stripe [LANES];
  logic [LANES-1:0]    w_dout;

  // Word boundary: the shifters reload on the edge that ends a word period.
  assign w_ld        = (r_bit_cnt == CNT_W'(WB - 1));
  assign w_sync_last = w_ld && (r_word_cnt == WCNT_W'(SYNC_WORDS - 1));
  assign w_accept    = tx.valid_in & w_ready;

  // Next state and handshake. ready is combinational so a word can enter the
  // hold register on the very edge that moves the previous word to the lanes,
  // which is what keeps back-to-back words gap-free.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    case (r_state)
      ST_SYNC: begin
        if (w_sync_last) w_state_nxt = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        w_ready = ~r_hold_full | w_ld;
      end
      default: begin
        w_state_nxt = ST_SYNC;
      end
    endcase
  end

  // Distribute the held word into per-lane shift images, slot 0 at the MSB.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      w_stripe[l] = '0;
      for (int k = 0; k < SPL; k++) begin
        w_stripe[l][WB-1-k*SYM_W -: SYM_W] = r_hold[DATA_W-1-(k*LANES+l)*SYM_W -: SYM_W];
      end
    end
  end

  // Control and lane shifters. The shifters are preset to the idle pattern so
  // the lanes show idle bit 7 during reset; the first edge after release
  // shifts, so lanes resume at idle bit 6 and any partial word is lost.
  always_ff @(posedge clk_32f or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_SYNC;
      r_bit_cnt     <= '0;
      r_word_cnt    <= '0;
      r_hold_full   <= 1'b0;
      r_data_active <= 1'b0;
      r_sync_done   <= 1'b0;
      for (int l = 0; l < LANES; l++) r_sh[l] <= IDLE_PAT;
    end else begin
      r_state   <= w_state_nxt;
      r_bit_cnt <= w_ld ? '0 : r_bit_cnt + 1'b1;

      if (r_state == ST_SYNC && w_ld) r_word_cnt <= r_word_cnt + 1'b1;
      if (r_state == ST_SYNC && w_sync_last) r_sync_done <= 1'b1;

      // Accept wins over the ld clear: on a shared edge the old word leaves
      // for the lanes and the new one takes its place in hold.
      if (w_accept)  r_hold_full <= 1'b1;
      else if (w_ld) r_hold_full <= 1'b0;

      if (w_ld) r_data_active <= r_hold_full;

      for (int l = 0; l < LANES; l++) begin
        if (w_ld) r_sh[l] <= r_hold_full ? w_stripe[l] : IDLE_PAT;
        else      r_sh[l] <= r_sh[l] << 1;
      end
    end
  end

  // Hold word payload; only meaningful while r_hold_full is set.
  always_ff @(posedge clk_32f) begin
    if (w_accept) r_hold <= tx.Data_in;
  end

  always_comb begin
    for (int l = 0; l < LANES; l++) w_dout[l] = r_sh[l][WB-1];
  end

  assign tx.Data_out    = w_dout;
  assign tx.ready_out   = w_ready;
  assign tx.data_active = r_data_active;
  assign tx.sync_done   = r_sync_done;

endmodule

// File: tb/tb_phy_tx_stripe_ser.sv
// -----------------------------------------------------------------------------
// tb_phy_tx_stripe_ser
// Drives two PHY instances from one clock and reset: dut 0 with 2 lanes and
// dut 1 with 4 lanes, both 32-bit words. A word-level model (elapsed-cycle
// arithmetic plus a one-word pending slot) predicts every output each cycle;
// directed scenarios add literal expectations for lane bit patterns, sync
// timing and data_active durations.
// -----------------------------------------------------------------------------
module tb_phy_tx_stripe_ser;

  localparam int SYNC = 4;

  logic        clk;
  logic        rst_n;
  logic        v [2];
  logic [31:0] d [2];
  logic [7:0]  idle_sym = 8'hBC;

  int n_checks = 0;
  int n_errs   = 0;

  phy_tx_stripe_ser_if #(.DATA_W(32), .LANES(2)) ifa ();
  phy_tx_stripe_ser_if #(.DATA_W(32), .LANES(4)) ifb ();

  assign ifa.valid_in = v[0];
  assign ifa.Data_in  = d[0];
  assign ifb.valid_in = v[1];
  assign ifb.Data_in  = d[1];

  phy_tx_stripe_ser #(.DATA_W(32), .LANES(2), .SYM_W(8), .IDLE_SYM(8'hBC), .SYNC_WORDS(SYNC))
    u_dut_a (.clk_32f(clk), .reset(rst_n), .tx(ifa));

  phy_tx_stripe_ser #(.DATA_W(32), .LANES(4), .SYM_W(8), .IDLE_SYM(8'hBC), .SYNC_WORDS(SYNC))
    u_dut_b (.clk_32f(clk), .reset(rst_n), .tx(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT accessors ----------------
  function automatic logic [3:0] dout(input int g);
    return (g == 0) ? {2'b00, ifa.Data_out} : ifb.Data_out;
  endfunction
  function automatic logic rdy(input int g);
    return (g == 0) ? ifa.ready_out : ifb.ready_out;
  endfunction
  function automatic logic dact(input int g);
    return (g == 0) ? ifa.data_active : ifb.data_active;
  endfunction
  function automatic logic sdone(input int g);
    return (g == 0) ? ifa.sync_done : ifb.sync_done;
  endfunction

  // ---------------- Model ----------------
  // m_t: rising edges since reset release. Word period p covers
  // t = p*WB .. p*WB+WB-1; period 0 is always idle. The pending slot holds at
  // most one accepted word, which is sent in the first period starting after
  // its acceptance.
  int          m_t    [2];
  logic        m_full [2];
  logic [31:0] m_hold [2];
  logic [31:0] m_cur  [2];
  logic        m_curd [2];

  function automatic int lanes_of(input int g);
    return (g == 0) ? 2 : 4;
  endfunction
  function automatic int wb_of(input int g);
    return 32 / lanes_of(g);
  endfunction
  function automatic logic m_active(input int g);
    return m_t[g] >= SYNC * wb_of(g);
  endfunction
  function automatic logic m_ready(input int g);
    return m_active(g) && (!m_full[g] || ((m_t[g] + 1) % wb_of(g) == 0));
  endfunction
  function automatic logic [3:0] exp_dout(input int g);
    logic [3:0] e;
    int j, k, b, s;
    e = '0;
    j = m_t[g] % wb_of(g);
    k = j / 8;
    b = 7 - (j % 8);
    for (int i = 0; i < lanes_of(g); i++) begin
      s = k * lanes_of(g) + i;
      e[i] = m_curd[g] ? m_cur[g][32 - (s + 1) * 8 + b] : idle_sym[b];
    end
    return e;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < 2; g++) begin
        m_t[g]    <= 0;
        m_full[g] <= 1'b0;
        m_hold[g] <= '0;
        m_cur[g]  <= '0;
        m_curd[g] <= 1'b0;
      end
    end else begin
      for (int g = 0; g < 2; g++) begin
        m_t[g] <= m_t[g] + 1;
        if ((m_t[g] + 1) % wb_of(g) == 0) begin
          m_curd[g] <= m_full[g];
          m_cur[g]  <= m_hold[g];
        end
        if (v[g] && m_ready(g)) begin
          m_hold[g] <= d[g];
          m_full[g] <= 1'b1;
        end else if ((m_t[g] + 1) % wb_of(g) == 0) begin
          m_full[g] <= 1'b0;
        end
      end
    end
  end

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s dut%0d at %0t: got %h expected %h", nm, g, $time, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        chk("Data_out",    g, {28'd0, dout(g)}, {28'd0, exp_dout(g)});
        chk("ready_out",   g, {31'd0, rdy(g)},   {31'd0, m_ready(g)});
        chk("data_active", g, {31'd0, dact(g)},  {31'd0, m_curd[g]});
        chk("sync_done",   g, {31'd0, sdone(g)}, {31'd0, m_active(g)});
      end
    end
  end

  // ---------------- Stimulus helpers ----------------
  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic send_word(input int g, input logic [31:0] w, output int waited);
    logic acc;
    acc    = 1'b0;
    waited = 0;
    v[g]   = 1'b1;
    d[g]   = w;
    while (!acc && waited < 300) begin
      acc = rdy(g);
      @(negedge clk);
      waited++;
    end
    chk("accept", g, {31'd0, acc}, 32'd1);
  endtask

  // Waits for data_active, then records lane bits while it stays high.
  task automatic capture(input int g, output logic [3:0][15:0] cap, output int act);
    int guard;
    guard = 0;
    act   = 0;
    cap   = '0;
    while (dact(g) == 1'b0 && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    chk("data_active seen", g, {31'd0, dact(g)}, 32'd1);
    while (dact(g) == 1'b1 && act < 100) begin
      for (int i = 0; i < 4; i++) cap[i] = {cap[i][14:0], dout(g)[i]};
      act++;
      @(negedge clk);
    end
  endtask

  // ---------------- Directed scenarios ----------------
  initial begin
    logic [7:0]       seq;
    logic [3:0][15:0] cap;
    int               act, w, ka, kb, ra;

    v[0] = 1'b0; v[1] = 1'b0;
    d[0] = '0;   d[1] = '0;
    rst_n = 1'b0;

    // Reset values, idle pattern and sync timing.
    repeat (3) @(negedge clk);
    chk("rst Data_out",  0, {28'd0, dout(0)}, 32'h3);
    chk("rst Data_out",  1, {28'd0, dout(1)}, 32'hF);
    chk("rst ready_out", 0, {31'd0, rdy(0)},   32'd0);
    chk("rst sync_done", 0, {31'd0, sdone(0)}, 32'd0);
    seq = {7'd0, dout(0)[0]};
    rst_n = 1'b1;
    ka = 0; kb = 0; ra = 0;
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      if (k < 8) seq = {seq[6:0], dout(0)[1]};
      if (ka == 0 && sdone(0)) ka = k;
      if (ra == 0 && rdy(0))   ra = k;
      if (kb == 0 && sdone(1)) kb = k;
    end
    chk("idle lane pattern",   0, {24'd0, seq}, 32'hBC);
    chk("sync_done cycle",     0, ka, 64);
    chk("ready_out first rise", 0, ra, 64);
    chk("sync_done cycle",     1, kb, 32);

    // Single word.
    send_word(0, 32'h12345678, w);
    v[0] = 1'b0;
    capture(0, cap, act);
    chk("single lane0", 0, {16'd0, cap[0]}, 32'h1256);
    chk("single lane1", 0, {16'd0, cap[1]}, 32'h3478);
    chk("single active cycles", 0, act, 16);
    repeat (20) @(negedge clk);

    // Streaming with valid held: four contiguous data periods.
    fork
      begin
        send_word(0, 32'hFFFFFFFF, w);
        send_word(0, 32'hEEEEEEEE, w);
        send_word(0, 32'hDDDDDDDD, w);
        send_word(0, 32'hCCCCCCCC, w);
        v[0] = 1'b0;
      end
      capture(0, cap, act);
    join
    chk("stream active cycles", 0, act, 64);
    chk("stream last lane0", 0, {16'd0, cap[0]}, 32'hCCCC);
    chk("stream last lane1", 0, {16'd0, cap[1]}, 32'hCCCC);
    repeat (20) @(negedge clk);

    // Backpressure with distinct words.
    fork
      begin
        send_word(0, 32'h01234567, w);
        send_word(0, 32'h89ABCDEF, w);
        send_word(0, 32'hDEADBEEF, w);
        v[0] = 1'b0;
      end
      capture(0, cap, act);
    join
    chk("bp active cycles", 0, act, 48);
    chk("bp last lane0", 0, {16'd0, cap[0]}, 32'hDEBE);
    chk("bp last lane1", 0, {16'd0, cap[1]}, 32'hADEF);
    repeat (20) @(negedge clk);

    // Reset in the middle of a word.
    send_word(0, 32'hAAAAAAAA, w);
    v[0] = 1'b0;
    w = 0;
    while (dact(0) == 1'b0 && w < 100) begin
      @(negedge clk);
      w++;
    end
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midword rst Data_out",    0, {28'd0, dout(0)}, 32'h3);
    chk("midword rst ready_out",   0, {31'd0, rdy(0)},   32'd0);
    chk("midword rst sync_done",   0, {31'd0, sdone(0)}, 32'd0);
    chk("midword rst data_active", 0, {31'd0, dact(0)},  32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    send_word(0, 32'h5A5A0FF0, w);
    v[0] = 1'b0;
    chk("post-reset accept wait", 0, w, 65);
    repeat (40) @(negedge clk);

    // Four-lane instance.
    send_word(1, 32'hAABBCCDD, w);
    v[1] = 1'b0;
    capture(1, cap, act);
    chk("4-lane lane0", 1, {24'd0, cap[0][7:0]}, 32'hAA);
    chk("4-lane lane1", 1, {24'd0, cap[1][7:0]}, 32'hBB);
    chk("4-lane lane2", 1, {24'd0, cap[2][7:0]}, 32'hCC);
    chk("4-lane lane3", 1, {24'd0, cap[3][7:0]}, 32'hDD);
    chk("4-lane active cycles", 1, act, 8);
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
